call_return_ctrl: RTL and testbench

//  Drives the 16-deep hardware return-address stack: the push/pop initiator for that stack.

---
 rtl/pic_cpu_pkg.sv | 30 +++
 rtl/stack_depth_mon.sv | 63 ++++++
 rtl/call_return_ctrl.sv | 141 ++++++++++++++
 tb/tb_call_return_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pic_cpu_pkg.sv
// Shared constants for the PIC-style CPU slice: opcode match patterns, the
// call/return controller state type and the hardware stack depth.
package pic_cpu_pkg;

  localparam int unsigned STK_DEPTH = 16;
  localparam int unsigned DEPTH_W   = 5;
  localparam int unsigned OP_W      = 14;

  // Opcode mask/match pairs; RETURN and RETFIE are exact encodings.
  localparam logic [OP_W-1:0] OP_CALL_MASK  = 14'h3800;
  localparam logic [OP_W-1:0] OP_CALL       = 14'h2000;
  localparam logic [OP_W-1:0] OP_RETURN     = 14'h0008;
  localparam logic [OP_W-1:0] OP_RETLW_MASK = 14'h3F00;
  localparam logic [OP_W-1:0] OP_RETLW      = 14'h3400;
  localparam logic [OP_W-1:0] OP_RETFIE     = 14'h0009;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } crc_state_t;

  function automatic logic is_call(input logic [OP_W-1:0] op);
    return (op & OP_CALL_MASK) == OP_CALL;
  endfunction

  function automatic logic is_retlw(input logic [OP_W-1:0] op);
    return (op & OP_RETLW_MASK) == OP_RETLW;
  endfunction

endpackage

// File: rtl/stack_depth_mon.sv
// Return-stack depth tracker with sticky overflow/underflow flags.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, pop             stack operations decided this cycle (pre-register)
//   stk_flag_clr          software clear of both flags; a same-cycle event wins
//   depth                 live entries 0..DEPTH (registered, aligned with strobes)
//   stkovf, stkunf        sticky error flags
//   stk_reset_req         1-cycle pulse on any ovf/unf event when
//                         STACK_RESET_ON_ERR_EN is defined, otherwise 0
module stack_depth_mon
  import pic_cpu_pkg::*;
#(
  parameter int unsigned DEPTH = STK_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               stk_flag_clr,
  output logic [DEPTH_W-1:0] depth,
  output logic               stkovf,
  output logic               stkunf,
  output logic               stk_reset_req
);

  logic ovf_evt_c;
  logic unf_evt_c;

  // The stack itself wraps; here we only hold depth and record the error.
  assign ovf_evt_c = push && (depth == DEPTH_W'(DEPTH));
  assign unf_evt_c = pop  && (depth == '0);

  // Depth counter and sticky flags; set has priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth  <= '0;
      stkovf <= 1'b0;
      stkunf <= 1'b0;
    end else begin
      if (push && !ovf_evt_c) begin
        depth <= depth + DEPTH_W'(1);
      end else if (pop && !unf_evt_c) begin
        depth <= depth - DEPTH_W'(1);
      end
      stkovf <= ovf_evt_c | (stkovf & ~stk_flag_clr);
      stkunf <= unf_evt_c | (stkunf & ~stk_flag_clr);
    end
  end

`ifdef STACK_RESET_ON_ERR_EN
  // Device-reset request pulse, aligned with the offending strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      stk_reset_req <= 1'b0;
    end else begin
      stk_reset_req <= ovf_evt_c | unf_evt_c;
    end
  end
`else
  assign stk_reset_req = 1'b0;
`endif

endmodule

// File: rtl/call_return_ctrl.sv
// Execute-stage call/return controller driving the hardware return stack.
// Decodes CALL, RETURN, RETLW, RETFIE and interrupt entry (irq wins over the
// instruction), producing registered push/pop/stack_in strobes, a PC redirect
// and a one-cycle flush after every redirect.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr, instr_valid  instruction in execute and its valid qualifier
//   pc_cur              address of instr
//   irq                 gated interrupt request
//   stack_out           current top of stack (sampled pre-pop)
//   stk_flag_clr        clears stkovf/stkunf
//   push, pop, stack_in stack strobes and push data
//   pc_load, pc_next    PC redirect
//   flush               squash the fetched instruction
//   gie_set, gie_clr    GIE control for RETFIE / interrupt entry
//   depth, stkovf, stkunf, stk_reset_req   from stack_depth_mon
// Config: STACK_RESET_ON_ERR_EN enables stk_reset_req pulses.
module call_return_ctrl
  import pic_cpu_pkg::*;
#(
  parameter int unsigned     PC_W       = 11,
  parameter int unsigned     DEPTH      = STK_DEPTH,
  parameter int unsigned     INSTR_W    = 14,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(4)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic [PC_W-1:0]    pc_cur,
  input  logic               irq,
  input  logic [PC_W-1:0]    stack_out,
  input  logic               stk_flag_clr,
  output logic               push,
  output logic               pop,
  output logic [PC_W-1:0]    stack_in,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_next,
  output logic               flush,
  output logic               gie_set,
  output logic               gie_clr,
  output logic [4:0]         depth,
  output logic               stkovf,
  output logic               stkunf,
  output logic               stk_reset_req
);

  crc_state_t      state_q, state_d;
  logic [OP_W-1:0] op;
  logic            push_d, pop_d, pc_load_d, flush_d, gie_set_d, gie_clr_d;
  logic [PC_W-1:0] stack_in_d, pc_next_d;

  assign op = OP_W'(instr);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      push     <= 1'b0;
      pop      <= 1'b0;
      stack_in <= '0;
      pc_load  <= 1'b0;
      pc_next  <= '0;
      flush    <= 1'b0;
      gie_set  <= 1'b0;
      gie_clr  <= 1'b0;
    end else begin
      state_q  <= state_d;
      push     <= push_d;
      pop      <= pop_d;
      stack_in <= stack_in_d;
      pc_load  <= pc_load_d;
      pc_next  <= pc_next_d;
      flush    <= flush_d;
      gie_set  <= gie_set_d;
      gie_clr  <= gie_clr_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    stack_in_d = '0;
    pc_load_d  = 1'b0;
    pc_next_d  = '0;
    flush_d    = 1'b0;
    gie_set_d  = 1'b0;
    gie_clr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (irq) begin
            // Interrupted instruction is re-executed on return.
            push_d     = 1'b1;
            stack_in_d = pc_cur;
            pc_next_d  = INT_VECTOR;
            gie_clr_d  = 1'b1;
          end else if (is_call(op)) begin
            push_d     = 1'b1;
            stack_in_d = pc_cur + PC_W'(1);
            pc_next_d  = PC_W'(op[10:0]);
          end else if (op == OP_RETURN || is_retlw(op)) begin
            pop_d      = 1'b1;
            pc_next_d  = stack_out;
          end else if (op == OP_RETFIE) begin
            pop_d      = 1'b1;
            pc_next_d  = stack_out;
            gie_set_d  = 1'b1;
          end
        end
        if (push_d || pop_d) begin
          pc_load_d = 1'b1;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        // Inputs ignored here; a held irq is taken on return to IDLE.
        flush_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  stack_depth_mon #(
    .DEPTH(DEPTH)
  ) u_depth_mon (
    .clk           (clk),
    .reset         (reset),
    .push          (push_d),
    .pop           (pop_d),
    .stk_flag_clr  (stk_flag_clr),
    .depth         (depth),
    .stkovf        (stkovf),
    .stkunf        (stkunf),
    .stk_reset_req (stk_reset_req)
  );

endmodule

// File: tb/tb_call_return_ctrl.sv
// Vector bench for call_return_ctrl: each table row is driven for one clock
// and the registered outputs are compared just after the edge.
module tb_call_return_ctrl;

`ifdef STACK_RESET_ON_ERR_EN
  localparam bit SRR_EN = 1'b1;
`else
  localparam bit SRR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] instr;
  logic        instr_valid;
  logic [10:0] pc_cur;
  logic        irq;
  logic [10:0] stack_out;
  logic        stk_flag_clr;
  logic        push, pop, pc_load, flush, gie_set, gie_clr;
  logic [10:0] stack_in, pc_next;
  logic [4:0]  depth;
  logic        stkovf, stkunf, stk_reset_req;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  call_return_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc_cur        (pc_cur),
    .irq           (irq),
    .stack_out     (stack_out),
    .stk_flag_clr  (stk_flag_clr),
    .push          (push),
    .pop           (pop),
    .stack_in      (stack_in),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .flush         (flush),
    .gie_set       (gie_set),
    .gie_clr       (gie_clr),
    .depth         (depth),
    .stkovf        (stkovf),
    .stkunf        (stkunf),
    .stk_reset_req (stk_reset_req)
  );

  typedef struct packed {
    logic [13:0] instr;
    logic        valid;
    logic [10:0] pc;
    logic        irq;
    logic [10:0] sout;
    logic        clr;
    logic        rst;
  } vin_t;

  typedef struct packed {
    logic        push;
    logic        pop;
    logic [10:0] sin;
    logic        load;
    logic [10:0] pnext;
    logic        flush;
    logic        gs;
    logic        gc;
    logic [4:0]  depth;
    logic        ovf;
    logic        unf;
    logic        srr;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t e;
  } vec_t;

  vec_t tbl[$];

  localparam logic [13:0] NOP    = 14'h0000;
  localparam logic [13:0] RETURN = 14'h0008;
  localparam logic [13:0] RETFIE = 14'h0009;

  function automatic vin_t vi(logic [13:0] ins, logic v, logic [10:0] pc,
                              logic irq_i, logic [10:0] so, logic clr, logic rst);
    vin_t r;
    r = '{instr: ins, valid: v, pc: pc, irq: irq_i, sout: so, clr: clr, rst: rst};
    return r;
  endfunction

  function automatic vout_t ve(logic ps, logic pp, logic [10:0] sin, logic ld,
                               logic [10:0] pn, logic fl, logic gs, logic gc,
                               logic [4:0] d, logic ovf, logic unf, logic srr);
    vout_t r;
    r = '{push: ps, pop: pp, sin: sin, load: ld, pnext: pn, flush: fl, gs: gs,
          gc: gc, depth: d, ovf: ovf, unf: unf, srr: srr & SRR_EN};
    return r;
  endfunction

  task automatic drive(input vin_t v);
    instr        = v.instr;
    instr_valid  = v.valid;
    pc_cur       = v.pc;
    irq          = v.irq;
    stack_out    = v.sout;
    stk_flag_clr = v.clr;
    reset        = v.rst;
  endtask

  task automatic step_check(input string name, input vin_t v, input vout_t exp);
    vout_t act;
    drive(v);
    @(posedge clk);
    #1;
    act = '{push: push, pop: pop, sin: stack_in, load: pc_load, pnext: pc_next,
            flush: flush, gs: gie_set, gc: gie_clr, depth: depth, ovf: stkovf,
            unf: stkunf, srr: stk_reset_req};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got push=%b pop=%b sin=%h ld=%b pn=%h fl=%b gs=%b gc=%b d=%0d ovf=%b unf=%b srr=%b, expected push=%b pop=%b sin=%h ld=%b pn=%h fl=%b gs=%b gc=%b d=%0d ovf=%b unf=%b srr=%b",
               name, act.push, act.pop, act.sin, act.load, act.pnext, act.flush,
               act.gs, act.gc, act.depth, act.ovf, act.unf, act.srr,
               exp.push, exp.pop, exp.sin, exp.load, exp.pnext, exp.flush,
               exp.gs, exp.gc, exp.depth, exp.ovf, exp.unf, exp.srr);
    end
  endtask

  initial begin
    drive(vi(NOP, 1'b0, 11'h0, 1'b0, 11'h0, 1'b0, 1'b1));
    repeat (2) @(posedge clk);

    // reset state
    tbl.push_back('{vi(NOP, 0, 11'h000, 0, 11'h000, 0, 1), ve(0,0,11'h000,0,11'h000,0,0,0,0,0,0,0)});
    // CALL 0x123 at 0x050, then flush with a RETURN ignored in FLUSH
    tbl.push_back('{vi(14'h2123, 1, 11'h050, 0, 11'h000, 0, 0), ve(1,0,11'h051,1,11'h123,0,0,0,1,0,0,0)});
    tbl.push_back('{vi(RETURN, 1, 11'h051, 0, 11'h051, 0, 0), ve(0,0,11'h000,0,11'h000,1,0,0,1,0,0,0)});
    // RETURN with stack_out=0x051
    tbl.push_back('{vi(RETURN, 1, 11'h052, 0, 11'h051, 0, 0), ve(0,1,11'h000,1,11'h051,0,0,0,0,0,0,0)});
    tbl.push_back('{vi(NOP, 1, 11'h051, 0, 11'h000, 0, 0), ve(0,0,11'h000,0,11'h000,1,0,0,0,0,0,0)});
    // irq beats CALL at 0x200
    tbl.push_back('{vi(14'h23FF, 1, 11'h200, 1, 11'h000, 0, 0), ve(1,0,11'h200,1,11'h004,0,0,1,1,0,0,0)});
    // irq held off in FLUSH, taken next IDLE cycle
    tbl.push_back('{vi(NOP, 1, 11'h300, 1, 11'h000, 0, 0), ve(0,0,11'h000,0,11'h000,1,0,0,1,0,0,0)});
    tbl.push_back('{vi(NOP, 1, 11'h004, 1, 11'h000, 0, 0), ve(1,0,11'h004,1,11'h004,0,0,1,2,0,0,0)});
    tbl.push_back('{vi(NOP, 1, 11'h005, 0, 11'h000, 0, 0), ve(0,0,11'h000,0,11'h000,1,0,0,2,0,0,0)});
    // RETFIE
    tbl.push_back('{vi(RETFIE, 1, 11'h010, 0, 11'h004, 0, 0), ve(0,1,11'h000,1,11'h004,0,1,0,1,0,0,0)});
    tbl.push_back('{vi(NOP, 1, 11'h011, 0, 11'h000, 0, 0), ve(0,0,11'h000,0,11'h000,1,0,0,1,0,0,0)});
    // RETLW
    tbl.push_back('{vi(14'h3455, 1, 11'h020, 0, 11'h200, 0, 0), ve(0,1,11'h000,1,11'h200,0,0,0,0,0,0,0)});
    tbl.push_back('{vi(NOP, 1, 11'h021, 0, 11'h000, 0, 0), ve(0,0,11'h000,0,11'h000,1,0,0,0,0,0,0)});
    // invalid CALL does nothing
    tbl.push_back('{vi(14'h2111, 0, 11'h030, 1, 11'h000, 0, 0), ve(0,0,11'h000,0,11'h000,0,0,0,0,0,0,0)});
    // RETURN at depth 0: underflow
    tbl.push_back('{vi(RETURN, 1, 11'h040, 0, 11'h123, 0, 0), ve(0,1,11'h000,1,11'h123,0,0,0,0,0,1,1)});
    tbl.push_back('{vi(NOP, 1, 11'h041, 0, 11'h000, 0, 0), ve(0,0,11'h000,0,11'h000,1,0,0,0,0,1,0)});
    tbl.push_back('{vi(NOP, 1, 11'h042, 0, 11'h000, 1, 0), ve(0,0,11'h000,0,11'h000,0,0,0,0,0,0,0)});
    // clear coinciding with new underflow: set wins
    tbl.push_back('{vi(RETURN, 1, 11'h043, 0, 11'h0AA, 1, 0), ve(0,1,11'h000,1,11'h0AA,0,0,0,0,0,1,1)});
    tbl.push_back('{vi(NOP, 1, 11'h044, 0, 11'h000, 0, 0), ve(0,0,11'h000,0,11'h000,1,0,0,0,0,1,0)});
    tbl.push_back('{vi(NOP, 1, 11'h045, 0, 11'h000, 1, 0), ve(0,0,11'h000,0,11'h000,0,0,0,0,0,0,0)});
    // CALL at 0x7FF wraps return address
    tbl.push_back('{vi(14'h2010, 1, 11'h7FF, 0, 11'h000, 0, 0), ve(1,0,11'h000,1,11'h010,0,0,0,1,0,0,0)});
    // reset during FLUSH
    tbl.push_back('{vi(NOP, 1, 11'h010, 0, 11'h000, 0, 1), ve(0,0,11'h000,0,11'h000,0,0,0,0,0,0,0)});
    // non-matching opcodes
    tbl.push_back('{vi(14'h0018, 1, 11'h011, 0, 11'h055, 0, 0), ve(0,0,11'h000,0,11'h000,0,0,0,0,0,0,0)});
    tbl.push_back('{vi(14'h2805, 1, 11'h012, 0, 11'h055, 0, 0), ve(0,0,11'h000,0,11'h000,0,0,0,0,0,0,0)});

    foreach (tbl[k]) begin
      step_check($sformatf("row%0d", k), tbl[k].i, tbl[k].e);
    end

    // 17 CALLs: depth saturates at 16 and the 17th overflows
    for (int i = 0; i < 17; i++) begin
      step_check($sformatf("call%0d", i),
                 vi(14'h2100, 1, 11'(i), 0, 11'h000, 0, 0),
                 ve(1, 0, 11'(i + 1), 1, 11'h100, 0, 0, 0,
                    (i < 16) ? 5'(i + 1) : 5'd16, i == 16, 0, i == 16));
      step_check($sformatf("call%0d_flush", i),
                 vi(NOP, 1, 11'h100, 0, 11'h000, 0, 0),
                 ve(0, 0, 11'h000, 0, 11'h000, 1, 0, 0,
                    (i < 16) ? 5'(i + 1) : 5'd16, i == 16, 0, 0));
    end
    step_check("pop_after_ovf", vi(RETURN, 1, 11'h101, 0, 11'h011, 0, 0),
               ve(0,1,11'h000,1,11'h011,0,0,0,15,1,0,0));
    step_check("pop_after_ovf_flush", vi(NOP, 1, 11'h011, 0, 11'h000, 0, 0),
               ve(0,0,11'h000,0,11'h000,1,0,0,15,1,0,0));
    step_check("ovf_clear", vi(NOP, 1, 11'h012, 0, 11'h000, 1, 0),
               ve(0,0,11'h000,0,11'h000,0,0,0,15,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
